// File: rtl/camera_pkg.sv
// ============================================================================
// Module   : camera_pkg
// Purpose  : Shared FSM encoding and constants for the camera download blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package camera_pkg;

    localparam int BYTE_W = 8;

    // Seven-segment code the camera shows when it is idle and ready.
    localparam logic [6:0] IDLE_DISPLAY = 7'b0111111;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_READY = 3'd1,
        ST_REQUEST    = 3'd2,
        ST_RECEIVE    = 3'd3,
        ST_DONE       = 3'd4
    } camState_t;

endpackage

`default_nettype wire

// File: rtl/camera_download_receiver_if.sv
// ============================================================================
// Module   : camera_download_receiver_if
// Purpose  : Camera-side link and host-side FIFO/status signals of the receiver.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface camera_download_receiver_if;
    import camera_pkg::*;

    logic              readyToDownload;
    logic [BYTE_W-1:0] curByte;
    logic              strobe;
    logic              start;
    logic              downloadReq;
    logic              rdEn;
    logic [BYTE_W-1:0] rdData;
    logic              empty;
    logic [3:0]        byteCount;
    logic [7:0]        checksum;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              overflow;

    modport slave (
        input  readyToDownload, curByte, strobe, start, rdEn,
        output downloadReq, rdData, empty, byteCount, checksum,
               busy, done, timeout, overflow
    );

    modport master (
        output readyToDownload, curByte, strobe, start, rdEn,
        input  downloadReq, rdData, empty, byteCount, checksum,
               busy, done, timeout, overflow
    );
endinterface

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Show-ahead synchronous FIFO; pointers carry an extra wrap bit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo
    import camera_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = BYTE_W
)(
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_pushData,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_popData,
    output logic             o_empty,
    output logic             o_full
);
    localparam int c_addrW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_addrW:0] r_wrPtr;
    logic [c_addrW:0] r_rdPtr;
    logic             w_wrEn;
    logic             w_rdEn;

    assign o_empty = (r_wrPtr == r_rdPtr);
    assign o_full  = (r_wrPtr[c_addrW] != r_rdPtr[c_addrW]) &&
                     (r_wrPtr[c_addrW-1:0] == r_rdPtr[c_addrW-1:0]);

    // A pop frees the head slot in the same cycle, so a push into a full FIFO lands.
    assign w_wrEn = i_push && (!o_full || i_pop);
    assign w_rdEn = i_pop && !o_empty;

    assign o_popData = r_mem[r_rdPtr[c_addrW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_rdEn) r_rdPtr <= r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_wrEn) r_mem[r_wrPtr[c_addrW-1:0]] <= i_pushData;
    end

endmodule

`default_nettype wire

// File: rtl/camera_download_receiver.sv
// ============================================================================
// Module   : camera_download_receiver
// Purpose  : Requests a camera buffer download and queues strobed bytes for the host.
// Revision : 1.0
// ============================================================================
`default_nettype none

module camera_download_receiver
    import camera_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int MAX_BYTES      = 10,
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  logic clock,
    input  logic reset,
    camera_download_receiver_if.slave bus
);
    localparam int                 c_timerW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_timerW-1:0] c_timerLast = c_timerW'(TIMEOUT_CYCLES - 1);

    camState_t           r_state;
    logic [1:0]          r_readySync;
    logic [1:0]          r_strobeSync;
    logic                r_strobePrev;
    logic                r_strobeEdge;
    logic [BYTE_W-1:0]   r_capByte;
    logic [c_timerW-1:0] r_timer;
    logic [3:0]          r_byteCount;
    logic [7:0]          r_checksum;
    logic                r_downloadReq;
    logic                r_busy;
    logic                r_done;
    logic                r_timeout;
    logic                r_overflow;

    logic                w_push;
    logic                w_full;
    logic                w_empty;
    logic [BYTE_W-1:0]   w_fifoData;
    logic                w_drop;
    logic [3:0]          w_countNext;
    logic [3:0]          w_countEff;
    logic                w_hitMax;
    logic                w_readyLost;

    // curByte is stable while strobe is high, so it is captured without a synchroniser.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_readySync  <= 2'b00;
            r_strobeSync <= 2'b00;
            r_strobePrev <= 1'b0;
            r_strobeEdge <= 1'b0;
            r_capByte    <= '0;
        end else begin
            r_readySync  <= {r_readySync[0], bus.readyToDownload};
            r_strobeSync <= {r_strobeSync[0], bus.strobe};
            r_strobePrev <= r_strobeSync[1];
            r_strobeEdge <= r_strobeSync[1] & ~r_strobePrev;
            if (r_strobeSync[1] & ~r_strobePrev) r_capByte <= bus.curByte;
        end
    end

    assign w_push      = (r_state == ST_RECEIVE) && r_strobeEdge;
    assign w_drop      = w_push && w_full && !bus.rdEn;
    assign w_countNext = (r_byteCount == 4'hF) ? 4'hF : r_byteCount + 4'd1;
    assign w_countEff  = r_strobeEdge ? w_countNext : r_byteCount;
    assign w_hitMax    = int'(w_countEff) >= MAX_BYTES;
    assign w_readyLost = !r_readySync[1] && (w_countEff != 4'd0);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .i_push     (w_push),
        .i_pushData (r_capByte),
        .i_pop      (bus.rdEn),
        .o_popData  (w_fifoData),
        .o_empty    (w_empty),
        .o_full     (w_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_byteCount   <= 4'd0;
            r_checksum    <= 8'd0;
            r_downloadReq <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state     <= ST_WAIT_READY;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_byteCount <= 4'd0;
                        r_checksum  <= 8'd0;
                        r_timeout   <= 1'b0;
                        r_overflow  <= 1'b0;
                    end
                end
                ST_WAIT_READY: begin
                    if (r_readySync[1]) begin
                        r_state       <= ST_REQUEST;
                        r_downloadReq <= 1'b1;
                    end
                end
                ST_REQUEST: begin
                    r_downloadReq <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= ST_RECEIVE;
                end
                ST_RECEIVE: begin
                    if (r_strobeEdge) begin
                        r_byteCount <= w_countNext;
                        r_checksum  <= r_checksum + r_capByte;
                        r_timer     <= '0;
                        if (w_drop) r_overflow <= 1'b1;
                    end else if (r_timer != c_timerLast) begin
                        r_timer <= r_timer + c_timerW'(1);
                    end

                    if (w_hitMax || w_readyLost) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (!r_strobeEdge && r_timer == c_timerLast) begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.downloadReq = r_downloadReq;
    assign bus.rdData      = w_fifoData;
    assign bus.empty       = w_empty;
    assign bus.byteCount   = r_byteCount;
    assign bus.checksum    = r_checksum;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.timeout     = r_timeout;
    assign bus.overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_camera_download_receiver.sv
// ============================================================================
// Module   : tb_camera_download_receiver
// Purpose  : Directed bench: default instance A and a shallow-FIFO instance B.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_camera_download_receiver;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   nCompared   = 0;
    int   nMismatched = 0;

    always #5 clock = ~clock;

    camera_download_receiver_if busA ();
    camera_download_receiver_if busB ();

    camera_download_receiver #(
        .FIFO_DEPTH (16), .MAX_BYTES (10), .TIMEOUT_CYCLES (1024)
    ) dutA (.clock (clock), .reset (reset), .bus (busA));

    camera_download_receiver #(
        .FIFO_DEPTH (4), .MAX_BYTES (6), .TIMEOUT_CYCLES (1024)
    ) dutB (.clock (clock), .reset (reset), .bus (busB));

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking inside) ----------------
    task automatic armA();
        busA.readyToDownload = 1'b1;
        busA.start = 1'b1;
        @(negedge clock);
        busA.start = 1'b0;
    endtask

    task automatic armB();
        busB.readyToDownload = 1'b1;
        busB.start = 1'b1;
        @(negedge clock);
        busB.start = 1'b0;
    endtask

    task automatic sendA(input logic [7:0] b);
        busA.curByte = b;
        busA.strobe  = 1'b1;
        repeat (5) @(negedge clock);
        busA.strobe  = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    task automatic sendB(input logic [7:0] b);
        busB.curByte = b;
        busB.strobe  = 1'b1;
        repeat (5) @(negedge clock);
        busB.strobe  = 1'b0;
        repeat (15) @(negedge clock);
    endtask

    task automatic popA(output logic [7:0] d);
        d = busA.rdData;
        busA.rdEn = 1'b1;
        @(negedge clock);
        busA.rdEn = 1'b0;
    endtask

    task automatic popB(output logic [7:0] d);
        d = busB.rdData;
        busB.rdEn = 1'b1;
        @(negedge clock);
        busB.rdEn = 1'b0;
    endtask

    task automatic waitDoneA(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (busA.done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    task automatic waitDoneB(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (busB.done === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [5:0] flags;
        flags = {busA.downloadReq, busA.busy, busA.done, busA.timeout, busA.overflow, busA.empty};
        nCompared++;
        if (flags !== 6'b000001) begin
            nMismatched++;
            $display("FAIL reset_flags: got %b required %b", flags, 6'b000001);
        end
        nCompared++;
        if (busA.byteCount !== 4'd0 || busA.checksum !== 8'd0) begin
            nMismatched++;
            $display("FAIL reset_counts: got cnt=%0d sum=%0h required 0/0", busA.byteCount, busA.checksum);
        end
        flags = {busB.downloadReq, busB.busy, busB.done, busB.timeout, busB.overflow, busB.empty};
        nCompared++;
        if (flags !== 6'b000001) begin
            nMismatched++;
            $display("FAIL reset_flags_b: got %b required %b", flags, 6'b000001);
        end
    endtask

    task automatic test_nominal();
        int n;
        bit ok;
        logic [7:0] d;
        armA();
        for (int i = 0; i < 20 && busA.downloadReq !== 1'b1; i++) @(negedge clock);
        n = 0;
        while (busA.downloadReq === 1'b1 && n < 8) begin n++; @(negedge clock); end
        nCompared++;
        if (n != 1) begin
            nMismatched++;
            $display("FAIL req_pulse: got %0d cycles required 1", n);
        end
        nCompared++;
        if (busA.busy !== 1'b1) begin
            nMismatched++;
            $display("FAIL busy_receive: got %b required 1", busA.busy);
        end
        // First byte: empty must still be 1 after three edges and drop after the fourth.
        busA.curByte = 8'h01;
        busA.strobe  = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        nCompared++;
        if (busA.empty !== 1'b1) begin
            nMismatched++;
            $display("FAIL latency_3clk: got empty=%b required 1", busA.empty);
        end
        @(posedge clock);
        #1;
        nCompared++;
        if (busA.empty !== 1'b0 || busA.rdData !== 8'h01) begin
            nMismatched++;
            $display("FAIL latency_4clk: got empty=%b data=%0h required 0/01", busA.empty, busA.rdData);
        end
        @(negedge clock);
        busA.strobe = 1'b0;
        repeat (15) @(negedge clock);
        for (int b = 2; b <= 10; b++) sendA(8'(b));
        waitDoneA(50, ok);
        nCompared++;
        if (!ok || busA.byteCount !== 4'd10 || busA.checksum !== 8'h37) begin
            nMismatched++;
            $display("FAIL nominal_done: got done=%b cnt=%0d sum=%0h required 1/10/37",
                     busA.done, busA.byteCount, busA.checksum);
        end
        nCompared++;
        if ({busA.busy, busA.timeout, busA.overflow} !== 3'b000) begin
            nMismatched++;
            $display("FAIL nominal_flags: got %b required 000", {busA.busy, busA.timeout, busA.overflow});
        end
        for (int b = 1; b <= 10; b++) begin
            popA(d);
            nCompared++;
            if (d !== 8'(b)) begin
                nMismatched++;
                $display("FAIL nominal_pop%0d: got %0h required %0h", b, d, b);
            end
        end
        nCompared++;
        if (busA.empty !== 1'b1) begin
            nMismatched++;
            $display("FAIL nominal_empty: got %b required 1", busA.empty);
        end
    endtask

    task automatic test_early_end();
        bit ok;
        logic [7:0] d;
        logic [7:0] exp [3];
        exp = '{8'h10, 8'h20, 8'h30};
        armA();
        repeat (5) @(negedge clock);
        for (int i = 0; i < 3; i++) sendA(exp[i]);
        busA.readyToDownload = 1'b0;
        waitDoneA(50, ok);
        nCompared++;
        if (!ok || busA.byteCount !== 4'd3 || busA.checksum !== 8'h60 || busA.timeout !== 1'b0) begin
            nMismatched++;
            $display("FAIL early_end: got done=%b cnt=%0d sum=%0h to=%b required 1/3/60/0",
                     busA.done, busA.byteCount, busA.checksum, busA.timeout);
        end
        for (int i = 0; i < 3; i++) begin
            popA(d);
            nCompared++;
            if (d !== exp[i]) begin
                nMismatched++;
                $display("FAIL early_pop%0d: got %0h required %0h", i, d, exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        logic [7:0] d;
        armA();
        repeat (5) @(negedge clock);
        sendA(8'h11);
        sendA(8'h22);
        waitDoneA(1200, ok);
        nCompared++;
        if (!ok || busA.timeout !== 1'b1 || busA.byteCount !== 4'd2 || busA.checksum !== 8'h33) begin
            nMismatched++;
            $display("FAIL timeout: got done=%b to=%b cnt=%0d sum=%0h required 1/1/2/33",
                     busA.done, busA.timeout, busA.byteCount, busA.checksum);
        end
        popA(d);
        popA(d);
    endtask

    task automatic test_overflow();
        bit ok;
        int n;
        logic [7:0] d;
        armB();
        repeat (5) @(negedge clock);
        for (int i = 0; i < 6; i++) sendB(8'hFF);
        waitDoneB(50, ok);
        nCompared++;
        if (!ok || busB.overflow !== 1'b1 || busB.byteCount !== 4'd6 || busB.checksum !== 8'hFA) begin
            nMismatched++;
            $display("FAIL overflow: got done=%b ovf=%b cnt=%0d sum=%0h required 1/1/6/FA",
                     busB.done, busB.overflow, busB.byteCount, busB.checksum);
        end
        n = 0;
        while (busB.empty === 1'b0 && n < 10) begin
            popB(d);
            n++;
            nCompared++;
            if (d !== 8'hFF) begin
                nMismatched++;
                $display("FAIL overflow_pop%0d: got %0h required FF", n, d);
            end
        end
        nCompared++;
        if (n != 4) begin
            nMismatched++;
            $display("FAIL overflow_occupancy: got %0d required 4", n);
        end
    endtask

    task automatic test_full_boundary();
        bit ok;
        int n;
        logic [7:0] d;
        logic [7:0] exp [4];
        exp = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
        armB();
        repeat (5) @(negedge clock);
        for (int i = 1; i <= 4; i++) sendB(8'(8'hA0 + i));
        // Fifth byte: pop the head on exactly the cycle the byte is written.
        busB.curByte = 8'hA5;
        busB.strobe  = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        d = busB.rdData;
        busB.rdEn = 1'b1;
        @(negedge clock);
        busB.rdEn = 1'b0;
        nCompared++;
        if (d !== 8'hA1 || busB.overflow !== 1'b0) begin
            nMismatched++;
            $display("FAIL boundary_pushpop: got head=%0h ovf=%b required A1/0", d, busB.overflow);
        end
        busB.strobe = 1'b0;
        repeat (15) @(negedge clock);
        busB.readyToDownload = 1'b0;
        waitDoneB(50, ok);
        nCompared++;
        if (!ok || busB.overflow !== 1'b0 || busB.byteCount !== 4'd5 || busB.checksum !== 8'h2F) begin
            nMismatched++;
            $display("FAIL boundary_done: got done=%b ovf=%b cnt=%0d sum=%0h required 1/0/5/2F",
                     busB.done, busB.overflow, busB.byteCount, busB.checksum);
        end
        n = 0;
        while (busB.empty === 1'b0 && n < 10) begin
            popB(d);
            nCompared++;
            if (n < 4 && d !== exp[n]) begin
                nMismatched++;
                $display("FAIL boundary_pop%0d: got %0h required %0h", n, d, exp[n]);
            end
            n++;
        end
        nCompared++;
        if (n != 4) begin
            nMismatched++;
            $display("FAIL boundary_occupancy: got %0d required 4", n);
        end
    endtask

    task automatic test_reset_mid_receive();
        bit ok;
        logic [5:0] flags;
        logic [7:0] d;
        armA();
        repeat (5) @(negedge clock);
        for (int b = 1; b <= 5; b++) sendA(8'(b));
        reset = 1'b1;
        #1;
        flags = {busA.downloadReq, busA.busy, busA.done, busA.timeout, busA.overflow, busA.empty};
        nCompared++;
        if (flags !== 6'b000001 || busA.byteCount !== 4'd0 || busA.checksum !== 8'd0) begin
            nMismatched++;
            $display("FAIL midreset_state: got flags=%b cnt=%0d sum=%0h required 000001/0/0",
                     flags, busA.byteCount, busA.checksum);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        armA();
        repeat (5) @(negedge clock);
        sendA(8'h05);
        sendA(8'h06);
        busA.readyToDownload = 1'b0;
        waitDoneA(50, ok);
        nCompared++;
        if (!ok || busA.byteCount !== 4'd2 || busA.checksum !== 8'h0B ||
            busA.timeout !== 1'b0 || busA.overflow !== 1'b0) begin
            nMismatched++;
            $display("FAIL midreset_rerun: got done=%b cnt=%0d sum=%0h required 1/2/0B",
                     busA.done, busA.byteCount, busA.checksum);
        end
        popA(d);
        nCompared++;
        if (d !== 8'h05) begin
            nMismatched++;
            $display("FAIL midreset_pop0: got %0h required 05", d);
        end
        popA(d);
        nCompared++;
        if (d !== 8'h06 || busA.empty !== 1'b1) begin
            nMismatched++;
            $display("FAIL midreset_pop1: got %0h empty=%b required 06/1", d, busA.empty);
        end
    endtask

    initial begin
        busA.readyToDownload = 1'b0; busA.curByte = 8'h00; busA.strobe = 1'b0;
        busA.start = 1'b0;           busA.rdEn = 1'b0;
        busB.readyToDownload = 1'b0; busB.curByte = 8'h00; busB.strobe = 1'b0;
        busB.start = 1'b0;           busB.rdEn = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        test_nominal();
        test_early_end();
        busA.readyToDownload = 1'b1;
        test_timeout();
        test_overflow();
        test_full_boundary();
        busA.readyToDownload = 1'b1;
        test_reset_mid_receive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/camera_download_receiver.md
Name: camera_download_receiver

Overview:
- Hardware receiving end of the camera buffer download link; replaces the software poll loop on the byte/strobe PIO pair.
- Watches a camera's ready-to-download flag and issues a download request.
- Captures each byte the camera buffer presents on its byte bus when the strobe rises, and queues bytes in a small FIFO for the host.
- Keeps a byte count and an 8-bit additive checksum; reports completion, timeout and overflow.

Parameters:
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- MAX_BYTES, 10, bytes per download; the transfer ends after this many accepted bytes.
- TIMEOUT_CYCLES, 1024, clock cycles without a new strobe edge before RECEIVE is abandoned.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- readyToDownload  in  1  camera idle/ready flag; may be asynchronous to clock
- curByte  in  8  byte presented by camera buffer; stable while strobe is high
- strobe  in  1  byte-valid strobe from camera buffer; may be asynchronous to clock
- start  in  1  one-cycle host pulse to arm a download
- downloadReq  out  1  download request to camera, active high
- rdEn  in  1  host FIFO pop
- rdData  out  8  FIFO head byte; valid when empty is 0
- empty  out  1  FIFO empty
- byteCount  out  4  bytes accepted in the current or last download
- checksum  out  8  modulo-256 sum of accepted bytes
- busy  out  1  FSM not in IDLE or DONE
- done  out  1  download finished; held until the next start
- timeout  out  1  sticky; RECEIVE abandoned because no strobe arrived
- overflow  out  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Input synchronisation:
  - readyToDownload and strobe each pass through a 2-FF synchroniser.
  - A strobe rising edge is detected on the synchronised signal, with one cycle of edge history.
  - curByte is sampled on the same cycle the edge is detected. It needs no synchroniser because it is stable while strobe is high.
- Reset values: downloadReq=0, byteCount=0, checksum=0, busy=0, done=0, timeout=0, overflow=0, empty=1. rdData is don't-care. FSM goes to IDLE and FIFO pointers go to 0.
- FSM states: IDLE, WAIT_READY, REQUEST, RECEIVE, DONE.
  - IDLE: on start, clear byteCount, checksum, done, timeout and overflow, then go to WAIT_READY. The FIFO is not flushed.
  - WAIT_READY: when synchronised ready=1, go to REQUEST.
  - REQUEST: assert downloadReq for exactly one cycle, clear the timeout counter, go to RECEIVE.
  - RECEIVE, on a strobe edge:
    - If the FIFO is not full: push curByte, byteCount+1, checksum+curByte modulo 256.
    - If the FIFO is full: drop the byte and set overflow. byteCount and checksum still advance, so the host can detect the loss.
    - Clear the timeout counter.
  - RECEIVE exits to DONE on the first of:
    - byteCount reaches MAX_BYTES, including the accepting cycle;
    - synchronised ready falls while byteCount > 0;
    - the timeout counter reaches TIMEOUT_CYCLES-1 with no edge, which also sets timeout.
  - DONE: done=1. On start, go to WAIT_READY with the same clears as IDLE.
- busy=1 in WAIT_READY, REQUEST and RECEIVE.
- Latency: curByte is visible at rdData (with empty=0) 4 clocks after strobe rises at the pin: 2 synchroniser stages, 1 edge detect, 1 FIFO write.
- FIFO:
  - Show-ahead FIFO: rdData is always the head entry.
  - rdEn while empty is ignored.
  - Push and pop in the same cycle when full are both allowed; the occupancy is unchanged and nothing is dropped.
  - Push and pop in the same cycle when empty: the pop is ignored and the push lands.
  - Pointers carry one extra wrap bit to distinguish full from empty.
- start outside IDLE/DONE is ignored.
- Reset mid-transfer: all state returns to reset values immediately; any partial FIFO contents are lost.
- byteCount saturates at 15.

Decomposition:
- Shared package camera_pkg holds:
  - the FSM state encoding, 3-bit;
  - BYTE_W=8;
  - IDLE_DISPLAY=7'b0111111, so every block agrees on the camera "ready" display code.
- One sub-module, sync_fifo (parameter DEPTH, width 8, show-ahead). It is reused later for the transmit direction.
- Synchroniser and edge detect stay inline.

Test Plan:
- Nominal: reset, start, ready=1, 10 strobes with bytes 0x01..0x0A spaced 20 clocks apart -> one-cycle downloadReq, done=1, byteCount=10, checksum=0x37, FIFO pops 0x01..0x0A, then empty=1.
- Early end: start, ready=1, 3 strobes with bytes 0x10, 0x20, 0x30, then ready=0 -> DONE, byteCount=3, checksum=0x60, timeout=0.
- Timeout: start, ready=1, 2 strobes, then no strobe for TIMEOUT_CYCLES -> DONE, timeout=1, byteCount=2.
- Overflow: FIFO_DEPTH=4, MAX_BYTES=6, no pops, 6 strobes of 0xFF -> overflow=1, FIFO holds 4 bytes, byteCount=6, checksum=0xFA.
- Full-boundary push/pop: FIFO full, strobe edge lands on the same cycle as rdEn -> overflow stays 0 and occupancy stays at 4.
- Reset mid-RECEIVE: after 5 bytes, pulse reset -> all outputs at reset values and empty=1; a later start runs a clean download.
